// File: rtl/dc_fifo_din_hyper.sv
// Write-side half of the HyperBus dual-clock FIFO: one-hot indexed register buffer,
// exported write token, and back-pressure derived from the synchronized read token.
module dc_fifo_din_hyper #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [BUFFER_DEPTH-1:0]            rd_token_async_i,
  output logic [BUFFER_DEPTH-1:0]            wr_token_o,
  output logic [BUFFER_DEPTH*DATA_WIDTH-1:0] buffer_o,
  output logic                               full_o
);

  localparam logic [BUFFER_DEPTH-1:0] TOKEN_RST = BUFFER_DEPTH'(1);

  logic [BUFFER_DEPTH-1:0]                 wr_token_q, wr_token_d;
  logic [BUFFER_DEPTH-1:0][DATA_WIDTH-1:0] buffer_q, buffer_d;
  logic [BUFFER_DEPTH-1:0]                 rd_sync1_q, rd_sync1_d;
  logic [BUFFER_DEPTH-1:0]                 rd_sync2_q, rd_sync2_d;

  logic [BUFFER_DEPTH-1:0] wr_token_rotl_c;
  logic                    full_c;
  logic                    write_en_c;

  // Full when the slot after the next write slot is the next slot to be read.
  assign wr_token_rotl_c = {wr_token_q[BUFFER_DEPTH-2:0], wr_token_q[BUFFER_DEPTH-1]};
  assign full_c          = |(wr_token_rotl_c & rd_sync2_q);
  assign write_en_c      = valid_i & ~full_c;

  // Next-state: token rotation, slot load and read-token synchronizer shift.
  always_comb begin
    wr_token_d = wr_token_q;
    buffer_d   = buffer_q;
    rd_sync1_d = rd_token_async_i;
    rd_sync2_d = rd_sync1_q;
    if (write_en_c) begin
      wr_token_d = wr_token_rotl_c;
      for (int unsigned k = 0; k < BUFFER_DEPTH; k++) begin
        if (wr_token_q[k]) begin
          buffer_d[k] = data_i;
        end
      end
    end
  end

  // Synchronizer resets to the read side's reset token so no false full appears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_token_q <= TOKEN_RST;
      buffer_q   <= '0;
      rd_sync1_q <= TOKEN_RST;
      rd_sync2_q <= TOKEN_RST;
    end else begin
      wr_token_q <= wr_token_d;
      buffer_q   <= buffer_d;
      rd_sync1_q <= rd_sync1_d;
      rd_sync2_q <= rd_sync2_d;
    end
  end

  assign ready_o    = ~full_c;
  assign full_o     = full_c;
  assign wr_token_o = wr_token_q;
  assign buffer_o   = buffer_q;

endmodule
